genmem_seq: RTL and testbench

- Byte-serial, bounds-checked read/write memory. It generalises the CPU's read-only multi-byte ROM into a RAM that supports writes.
- Accesses of 1..2**EXTRA little-endian bytes are accepted over a request/done handshake.
- Addresses are checked against a programmable lower/upper window. An out-of-window access is refused with an error.
- Sits between the CPU's memory port and the linear-memory/data region, so stores and traps are honoured.

---
 rtl/genmem_seq.sv | 147 ++++++++++++++
 tb/tb_genmem_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/genmem_seq.sv
`default_nettype none
// ============================================================================
// Module   : genmem_seq
// Purpose  : Byte-serial, bounds-checked read/write memory. An access of
//            1..2**EXTRA little-endian words is accepted on req in IDLE,
//            checked against an inclusive [lower_bound, upper_bound] window,
//            then transferred one word per clock. done pulses for one cycle
//            at the end; error flags a refused (out-of-window) access.
// Ports    : clk          - clock, rising edge
//            reset        - asynchronous active-low reset
//            req/we       - access request / 1=write 0=read
//            addr/extra   - first word address / word count minus one
//            lower_bound  - lowest legal address (inclusive)
//            upper_bound  - highest legal address (inclusive)
//            wdata/rdata  - write / read data, word i at [i*DW +: DW]
//            busy/done    - not IDLE / one-cycle completion pulse
//            error        - bounds fault of the completed access
// Revision : 1.0 - initial release
// ============================================================================
module genmem_seq #(
  parameter int    AW      = 4,
  parameter int    DW      = 8,
  parameter int    EXTRA   = 4,
  parameter string MEMFILE = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      we,
  input  logic [AW:0]               addr,
  input  logic [EXTRA-1:0]          extra,
  input  logic [AW:0]               lower_bound,
  input  logic [AW:0]               upper_bound,
  input  logic [(2**EXTRA)*DW-1:0]  wdata,
  output logic [(2**EXTRA)*DW-1:0]  rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int c_nw    = 2**EXTRA;
  localparam int c_bw    = c_nw * DW;
  localparam int c_depth = 2**(AW+1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_xfer = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;

  logic             r_we;
  logic [AW:0]      r_addr;
  logic [EXTRA-1:0] r_extra;
  logic [EXTRA-1:0] r_cnt;
  logic [c_bw-1:0]  r_wdata;
  logic [c_bw-1:0]  r_rdata;
  logic             r_error;

  logic [DW-1:0]    r_mem [c_depth];

  logic [AW+1:0]    w_end;
  logic             w_fault;
  logic [AW:0]      w_maddr;
  logic             w_last;
  logic             w_accept;
  int               w_lane;

  // One extra bit on the end address exposes a carry out of the address
  // space, which is refused rather than allowed to wrap to address 0.
  assign w_end    = {1'b0, addr} + (AW+2)'(extra);
  assign w_fault  = (addr < lower_bound) || (w_end > {1'b0, upper_bound}) || w_end[AW+1];
  assign w_maddr  = r_addr + (AW+1)'(r_cnt);
  assign w_last   = (r_cnt == r_extra);
  assign w_accept = (r_state == c_st_idle) && req;
  assign w_lane   = int'(r_cnt) * DW;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: if (req) w_next = w_fault ? c_st_done : c_st_xfer;
      c_st_xfer: if (w_last) w_next = c_st_done;
      c_st_done: w_next = c_st_idle;
      default:   w_next = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state != c_st_idle);
    done = (r_state == c_st_done);
  end

  assign rdata = r_rdata;
  assign error = r_error;

  // Access latch, word counter and read assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_extra <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_we    <= we;
      r_addr  <= addr;
      r_extra <= extra;
      r_wdata <= wdata;
      r_cnt   <= '0;
      r_error <= w_fault;
      // Clearing on a read guarantees words above extra read back as 0.
      if (w_fault || !we) begin
        r_rdata <= '0;
      end
    end else if (r_state == c_st_xfer) begin
      if (!r_we) begin
        r_rdata[w_lane +: DW] <= r_mem[w_maddr];
      end
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Memory write port; state is forced to IDLE by reset, so an aborted
  // write simply stops after the words already stored.
  always_ff @(posedge clk) begin
    if ((r_state == c_st_xfer) && r_we) begin
      r_mem[w_maddr] <= r_wdata[w_lane +: DW];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_genmem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_genmem_seq
// Purpose  : Self-checking bench for genmem_seq (AW=4, DW=8, EXTRA=4).
//            A behavioural model tracks accepted accesses by edge count and
//            a plain byte array, and is compared with the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_genmem_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req = 1'b0;
  logic         we = 1'b0;
  logic [4:0]   addr = '0;
  logic [3:0]   extra = '0;
  logic [4:0]   lower_bound = '0;
  logic [4:0]   upper_bound = 5'd31;
  logic [127:0] wdata = '0;
  logic [127:0] rdata;
  logic         busy;
  logic         done;
  logic         error;

  genmem_seq #(.AW(4), .DW(8), .EXTRA(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .extra       (extra),
    .lower_bound (lower_bound),
    .upper_bound (upper_bound),
    .wdata       (wdata),
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]   mm [32];
  logic         m_active = 1'b0;
  logic         m_fault  = 1'b0;
  logic         m_we     = 1'b0;
  int           m_k      = 0;
  int           m_n      = 1;
  int           m_addr   = 0;
  logic [127:0] m_wd     = '0;
  logic [127:0] m_rd     = '0;
  logic         m_err    = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 1'b0;
      m_rd     = '0;
      m_err    = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (!m_fault && m_k >= 1 && m_k <= m_n) begin
        if (m_we) mm[m_addr + m_k - 1] = m_wd[(m_k-1)*8 +: 8];
        else      m_rd[(m_k-1)*8 +: 8] = mm[m_addr + m_k - 1];
      end
      if (m_k == (m_fault ? 1 : m_n + 1)) m_active = 1'b0;
    end else if (req) begin
      m_active = 1'b1;
      m_k      = 0;
      m_we     = we;
      m_addr   = int'(addr);
      m_n      = int'(extra) + 1;
      m_wd     = wdata;
      m_fault  = (addr < lower_bound) ||
                 (int'(addr) + int'(extra) > int'(upper_bound)) ||
                 (int'(addr) + int'(extra) > 31);
      m_err    = m_fault;
      if (m_fault || !we) m_rd = '0;
    end
    #1;
    check("busy",  busy,  m_active);
    check("done",  done,  m_active && (m_k == (m_fault ? 0 : m_n)));
    check("error", error, m_err);
    check("rdata", rdata, m_rd);
  end

  // ---------------- stimulus helpers ----------------
  logic [127:0] d_rdata;
  logic         d_err;

  // One access; cyc counts edges from the accepting edge up to the edge
  // after which done is seen. Inputs are scrambled right after accept.
  task automatic do_access(input logic w, input logic [4:0] a, input logic [3:0] x,
                           input logic [4:0] lo, input logic [4:0] hi,
                           input logic [127:0] wd, output int cyc);
    bit seen;
    @(negedge clk);
    we = w; addr = a; extra = x; lower_bound = lo; upper_bound = hi; wdata = wd;
    req = 1'b1;
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (i == 0) begin
        req = 1'b0;
        addr = 5'($urandom); extra = 4'($urandom); we = 1'($urandom);
        lower_bound = 5'($urandom); upper_bound = 5'($urandom);
        wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_fail++;
      $display("FAIL access_timeout: got no done expected done within 40 cycles");
    end
    d_rdata = rdata;
    d_err   = error;
    @(posedge clk); #1;
  endtask

  logic [127:0] wd0, wd1, rd2;
  int           cyc, dcount, dfirst;
  logic         rw;
  logic [4:0]   ra, rlo, rhi;
  logic [3:0]   rx;
  bit           rf;

  initial begin
    // reset low for three cycles, then idle
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("idle_rdata", rdata, 128'h0);
    check("idle_busy",  busy,  1'b0);
    check("idle_done",  done,  1'b0);
    check("idle_error", error, 1'b0);

    // fill the whole array with mem[i] = i*7+3
    for (int i = 0; i < 16; i++) begin
      wd0[i*8 +: 8] = 8'(i*7 + 3);
      wd1[i*8 +: 8] = 8'((i+16)*7 + 3);
    end
    do_access(1'b1, 5'd0,  4'd15, 5'd0, 5'd31, wd0, cyc);
    check("fill_lat", 32'(cyc), 32'd17);
    do_access(1'b1, 5'd16, 4'd15, 5'd0, 5'd31, wd1, cyc);

    // wrap fault: 30..33 would wrap past the top of memory
    do_access(1'b1, 5'd30, 4'd3, 5'd0, 5'd31, 128'hFFFF_FFFF, cyc);
    check("wrap_err", d_err, 1'b1);
    check("wrap_lat", 32'(cyc), 32'd1);
    do_access(1'b0, 5'd30, 4'd1, 5'd0, 5'd31, '0, cyc);
    check("wrap_top", d_rdata, 128'hDCD5);
    do_access(1'b0, 5'd0, 4'd1, 5'd0, 5'd31, '0, cyc);
    check("wrap_bot", d_rdata, 128'h0A03);

    // multi-word write then read
    do_access(1'b1, 5'd4, 4'd3, 5'd0, 5'd31, 128'h2A1B0C0D, cyc);
    check("mw_wlat", 32'(cyc), 32'd5);
    check("mw_werr", d_err, 1'b0);
    do_access(1'b0, 5'd4, 4'd3, 5'd0, 5'd31, '0, cyc);
    check("mw_rlat",  32'(cyc), 32'd5);
    check("mw_rdata", d_rdata, 128'h2A1B0C0D);

    // bounds fault: end 16 exceeds upper bound 15
    do_access(1'b0, 5'd14, 4'd2, 5'd8, 5'd15, '0, cyc);
    check("bnd_err",   d_err, 1'b1);
    check("bnd_lat",   32'(cyc), 32'd1);
    check("bnd_rdata", d_rdata, 128'h0);
    do_access(1'b0, 5'd14, 4'd1, 5'd8, 5'd15, '0, cyc);
    check("bnd_legal", d_rdata, 128'h6C65);
    check("bnd_lerr",  d_err, 1'b0);

    // busy handling: req held through XFER and DONE of an 8-word read
    @(negedge clk);
    we = 1'b0; addr = 5'd0; extra = 4'd7; lower_bound = 5'd0; upper_bound = 5'd31;
    req = 1'b1;
    dcount = 0;
    dfirst = -10;
    rd2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dcount++;
        if (dcount == 1) begin
          dfirst = i;
          addr = 5'd4; extra = 4'd3; we = 1'b0;
          lower_bound = 5'd0; upper_bound = 5'd31;
        end
        if (dcount == 2) rd2 = rdata;
      end
      if (dcount == 0) begin
        addr = 5'($urandom); extra = 4'($urandom); we = 1'($urandom);
      end
      if (i == dfirst + 2) req = 1'b0;
    end
    req = 1'b0;
    check("busy_dones", 32'(dcount), 32'd2);
    check("busy_third", rd2, 128'h2A1B0C0D);

    // reset mid-write
    do_access(1'b1, 5'd0, 4'd7, 5'd0, 5'd31, 128'hF7F6F5F4F3F2F1F0, cyc);
    @(negedge clk);
    we = 1'b1; addr = 5'd0; extra = 4'd7; lower_bound = 5'd0; upper_bound = 5'd31;
    wdata = 128'h8877665544332211;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_error", error, 1'b0);
    check("rst_rdata", rdata, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 5'd0, 4'd7, 5'd0, 5'd31, '0, cyc);
    check("rst_mem", d_rdata, 128'hF7F6F5F4F3332211);

    // randomized accesses against the model
    for (int t = 0; t < 200; t++) begin
      rw = 1'($urandom);
      ra = 5'($urandom);
      rx = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        rlo = 5'd0; rhi = 5'd31;
      end else begin
        rlo = 5'($urandom); rhi = 5'($urandom);
      end
      rf = (ra < rlo) || (int'(ra) + int'(rx) > int'(rhi)) || (int'(ra) + int'(rx) > 31);
      do_access(rw, ra, rx, rlo, rhi, {$urandom, $urandom, $urandom, $urandom}, cyc);
      check("rand_lat", 32'(cyc), rf ? 32'd1 : 32'(int'(rx) + 2));
      check("rand_err", d_err, rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
